// File: rtl/shift_ctrl_pkg.sv
// Shared constants and types for the barrel-shifter button command controller.
package shift_ctrl_pkg;

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned SHAMT_W = 4;

    localparam int unsigned BTN_INC  = 0;
    localparam int unsigned BTN_DEC  = 1;
    localparam int unsigned BTN_DIR  = 2;
    localparam int unsigned BTN_MODE = 3;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic {
        MODE_LOGICAL = 1'b0,
        MODE_ROTATE  = 1'b1
    } mode_t;

    // Isolate the lowest set bit: bit 0 has the highest priority.
    function automatic logic [NUM_BTN-1:0] lowest_one(input logic [NUM_BTN-1:0] v);
        return v & (~v + NUM_BTN'(1));
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button channel: 2-flop synchronizer, debounce counter and
// a rising-edge press pulse derived from the debounced level.
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic clk_1kHz,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_c
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            if (sync_q2 != level) begin
                if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                    level <= sync_q2;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_c = level & ~level_q;

endmodule

// File: rtl/shift_cmd_ctrl.sv
// Button command controller: conditions four buttons, arbitrates presses and
// auto-repeats, and drives the barrel shifter configuration registers.
module shift_cmd_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 8,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic               clk_1kHz,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [SHAMT_W-1:0] shamt,
    output logic               dir,
    output logic               mode,
    output logic               cfg_valid
);

    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);

    logic [NUM_BTN-1:0] req_c;
    logic [NUM_BTN-1:0] inj_c;
    logic [NUM_BTN-1:0] cand_c;
    logic [NUM_BTN-1:0] grant_c;
    logic [NUM_BTN-1:0] pending_q;
    logic               upd_q;

    rpt_state_t         state_q, state_d;
    logic               rb_q, rb_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic               rb_held_c;
    logic               active_c;
    logic               due_c;
    logic               exec_incdec_c;
    logic               exec_dec_c;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_conditioner #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_cond (
            .clk_1kHz(clk_1kHz),
            .rst     (rst),
            .raw     (btn_raw[i]),
            .level   (btn_state[i]),
            .press_c (req_c[i])
        );
    end

    // rb_q selects the tracked button: 0 = INC, 1 = DEC.
    assign rb_held_c = rb_q ? btn_state[BTN_DEC] : btn_state[BTN_INC];
    assign active_c  = (state_q != RPT_IDLE) && rb_held_c;
    assign due_c     = active_c &&
                       (((state_q == RPT_HOLD)   && (tmr_q == TMR_W'(REPEAT_DELAY - 1))) ||
                        ((state_q == RPT_REPEAT) && (tmr_q == TMR_W'(REPEAT_RATE - 1))));

    assign inj_c     = {2'b00, due_c & rb_q, due_c & ~rb_q};
    assign cand_c    = pending_q | req_c | inj_c;
    assign grant_c   = lowest_one(cand_c);

    assign exec_incdec_c = grant_c[BTN_INC] | grant_c[BTN_DEC];
    assign exec_dec_c    = grant_c[BTN_DEC];

    // Auto-repeat state register.
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            state_q <= RPT_IDLE;
            rb_q    <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            rb_q    <= rb_d;
            tmr_q   <= tmr_d;
        end
    end

    // Release beats a due repeat; an executed INC/DEC on a new button re-arms the hold.
    always_comb begin
        state_d = state_q;
        rb_d    = rb_q;
        tmr_d   = tmr_q;
        case (state_q)
            RPT_IDLE: begin
                tmr_d = tmr_q;
            end
            RPT_HOLD, RPT_REPEAT: begin
                if (!rb_held_c) begin
                    state_d = RPT_IDLE;
                end else if (due_c) begin
                    state_d = RPT_REPEAT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = RPT_IDLE;
            end
        endcase
        if (exec_incdec_c && (!active_c || (exec_dec_c != rb_q))) begin
            state_d = RPT_HOLD;
            rb_d    = exec_dec_c;
            tmr_d   = '0;
        end
    end

    // Command execution and configuration registers.
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            upd_q     <= 1'b0;
            cfg_valid <= 1'b0;
            shamt     <= '0;
            dir       <= DIR_LEFT;
            mode      <= MODE_LOGICAL;
        end else begin
            pending_q <= cand_c & ~grant_c;
            upd_q     <= |grant_c;
            cfg_valid <= upd_q;
            if (grant_c[BTN_INC]) begin
                shamt <= shamt + SHAMT_W'(1);
            end
            if (grant_c[BTN_DEC]) begin
                shamt <= shamt - SHAMT_W'(1);
            end
            if (grant_c[BTN_DIR]) begin
                dir <= ~dir;
            end
            if (grant_c[BTN_MODE]) begin
                mode <= ~mode;
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
// Directed plus randomized bench for shift_cmd_ctrl with a cycle-level
// behavioural model built from the button/command rules.
module tb_shift_cmd_ctrl;

    localparam int DEB  = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;

    logic       clk_1kHz = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] btn_raw  = 4'd0;
    logic [3:0] btn_state;
    logic [3:0] shamt;
    logic       dir;
    logic       mode;
    logic       cfg_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cfg_seen = 0;
    int cfg_mark = 0;

    // Behavioural model state
    logic [3:0] m_lvl, m_req, m_pend, m_shamt, m_s1, m_s2;
    logic       m_dir, m_mode, m_upd, m_cfg, m_act;
    int         m_rb, m_due, edge_n;
    bit         m_hist [4][$];

    shift_cmd_ctrl #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE)
    ) dut (
        .clk_1kHz (clk_1kHz),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_state(btn_state),
        .shamt    (shamt),
        .dir      (dir),
        .mode     (mode),
        .cfg_valid(cfg_valid)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_lvl = 4'd0; m_req = 4'd0; m_pend = 4'd0; m_shamt = 4'd0;
        m_s1 = 4'd0; m_s2 = 4'd0;
        m_dir = 1'b0; m_mode = 1'b0; m_upd = 1'b0; m_cfg = 1'b0; m_act = 1'b0;
        m_rb = 0; m_due = 0;
        for (int i = 0; i < 4; i++) m_hist[i].delete();
    endfunction

    // One clock edge of the reference: commands use the values of the ending cycle.
    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] inj, cand, seen, lvl_new;
        int g;
        bit differ;
        m_cfg = m_upd;
        m_upd = 1'b0;
        inj   = 4'd0;
        if (m_act) begin
            if (!m_lvl[m_rb]) m_act = 1'b0;
            else if (edge_n == m_due) begin
                inj[m_rb] = 1'b1;
                m_due = edge_n + RATE;
            end
        end
        cand = m_pend | m_req | inj;
        g = -1;
        for (int i = 0; i < 4; i++) if (cand[i] && g < 0) g = i;
        if (g >= 0) begin
            cand[g] = 1'b0;
            m_upd = 1'b1;
            case (g)
                0: m_shamt = m_shamt + 4'd1;
                1: m_shamt = m_shamt - 4'd1;
                2: m_dir   = ~m_dir;
                default: m_mode = ~m_mode;
            endcase
            if (g < 2 && (!m_act || g != m_rb)) begin
                m_act = 1'b1;
                m_rb  = g;
                m_due = edge_n + DLY;
            end
        end
        m_pend = cand;
        // Debounce: level follows once the last DEB synced samples all disagree.
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        for (int i = 0; i < 4; i++) begin
            m_hist[i].push_back(seen[i]);
            if (m_hist[i].size() > DEB) void'(m_hist[i].pop_front());
            lvl_new[i] = m_lvl[i];
            if (m_hist[i].size() == DEB) begin
                differ = 1'b1;
                foreach (m_hist[i][k]) if (m_hist[i][k] == m_lvl[i]) differ = 1'b0;
                if (differ) lvl_new[i] = ~m_lvl[i];
            end
        end
        m_req = lvl_new & ~m_lvl;
        m_lvl = lvl_new;
        edge_n++;
    endfunction

    task automatic tick(input logic [3:0] raw, input logic rst_v);
        @(negedge clk_1kHz);
        btn_raw = raw;
        rst     = rst_v;
        @(posedge clk_1kHz);
        #1;
        if (rst) model_reset();
        else model_edge(raw);
        chk("cycle", {21'd0, btn_state, shamt, dir, mode, cfg_valid},
                     {21'd0, m_lvl, m_shamt, m_dir, m_mode, m_cfg});
        if (cfg_valid === 1'b1) cfg_seen++;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        for (int i = 0; i < hold; i++) tick(mask, 1'b0);
        for (int i = 0; i < 12; i++) tick(4'd0, 1'b0);
    endtask

    initial begin
        edge_n = 0;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) tick(4'd0, 1'b1);
        chk("reset_state", {24'd0, btn_state, shamt}, 32'd0);
        chk("reset_flags", {29'd0, dir, mode, cfg_valid}, 32'd0);
        tick(4'd0, 1'b0);

        // Glitches shorter than the debounce window
        for (int p = 0; p < 8; p++) begin
            logic [3:0] gm;
            int w;
            gm = 4'($urandom_range(1, 15));
            w  = $urandom_range(1, DEB - 1);
            for (int i = 0; i < w; i++) tick(gm, 1'b0);
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(4'd0, 1'b0);
        end
        for (int i = 0; i < 8; i++) tick(4'd0, 1'b0);
        chk("glitch_cfg", {26'd0, btn_state, dir, mode}, 32'd0);
        chk("glitch_shamt", {28'd0, shamt}, 32'd0);
        chk("glitch_pulses", cfg_seen, 32'd0);

        // Noisy INC press
        cfg_mark = cfg_seen;
        for (int p = 0; p < int'($urandom_range(2, 4)); p++) begin
            tick(4'b0001, 1'b0);
            tick(4'b0000, 1'b0);
        end
        press(4'b0001, 8);
        chk("noisy_inc", {28'd0, shamt}, 32'd1);
        chk("noisy_inc_pulses", cfg_seen - cfg_mark, 32'd1);

        // Wrap-around
        press(4'b0010, 8);
        chk("dec_to_0", {28'd0, shamt}, 32'd0);
        press(4'b0010, 8);
        chk("dec_wrap", {28'd0, shamt}, 32'd15);
        press(4'b0001, 8);
        chk("inc_wrap", {28'd0, shamt}, 32'd0);

        // Simultaneous INC, DIR, MODE
        cfg_mark = cfg_seen;
        press(4'b1101, 8);
        chk("simul_cfg", {26'd0, shamt, dir, mode}, {26'd0, 4'd1, 1'b1, 1'b1});
        chk("simul_pulses", cfg_seen - cfg_mark, 32'd3);

        // Held INC: press plus repeats every RATE after DLY
        press(4'b0001, 36);
        chk("hold_inc", {28'd0, shamt}, 32'd11);
        // Release landing on the first / second due repeat
        press(4'b0001, 10);
        chk("rel_on_first_due", {28'd0, shamt}, 32'd12);
        press(4'b0001, 13);
        chk("rel_on_repeat_due", {28'd0, shamt}, 32'd14);
        press(4'b0001, 14);
        chk("rel_after_repeat", {28'd0, shamt}, 32'd1);

        // Retarget INC repeat to DEC
        for (int i = 0; i < 20; i++) tick(4'b0001, 1'b0);
        for (int i = 0; i < 20; i++) tick(4'b0011, 1'b0);
        for (int i = 0; i < 12; i++) tick(4'b0000, 1'b0);
        chk("retarget", {28'd0, shamt}, 32'd1);

        // Asynchronous reset mid-repeat with INC held
        for (int i = 0; i < 25; i++) tick(4'b0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {21'd0, btn_state, shamt, dir, mode, cfg_valid}, 32'd0);
        model_reset();
        for (int i = 0; i < 2; i++) tick(4'b0001, 1'b1);
        for (int i = 0; i < 6; i++) tick(4'b0001, 1'b0);
        chk("rst_redetect", {24'd0, btn_state, shamt}, {24'd0, 4'b0001, 4'd0});
        tick(4'b0001, 1'b0);
        chk("rst_first_inc", {28'd0, shamt}, 32'd1);
        for (int i = 0; i < 12; i++) tick(4'b0000, 1'b0);

        // Randomized episodes against the model
        for (int e = 0; e < 25; e++) begin
            logic [3:0] rm;
            int h;
            rm = 4'($urandom_range(0, 15));
            h  = $urandom_range(1, 25);
            for (int i = 0; i < h; i++) tick(rm, 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 14)); i++) tick(4'd0, 1'b0);
        end
        for (int i = 0; i < 15; i++) tick(4'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
